i2s_rx: RTL and testbench
=========================

# i2s_rx

Serial-to-parallel I2S receiver: the receive-side counterpart of the board's I2S transmit path (BCLK/LRCK/DIN). It oversamples the three I2S lines in the `clk_p` domain and recovers MSB-first, one-bit-delayed left/right words. It presents them as a parallel stereo sample with a one-cycle valid strobe. It serves as an external ADC input, and as a loopback checker for the audio output chain on the Tang Nano 20K.

## Interface
Parameters:
- `DATA_W`, 16: output word width; the first `DATA_W` bits of each slot are captured.
- `SLOT_MAX`, 64: longest legal slot, in BCLK periods; longer slots flag an error.

Ports:
- `clk_p` in 1: sole clock (pixel clock, 25.2 MHz on this board).
- `reset` in 1: synchronous, active-high reset.
- `i2s_bclk` in 1: asynchronous serial bit clock. BCLK ≤ `clk_p`/4, each phase ≥ 2 `clk_p` cycles.
- `i2s_lrck` in 1: asynchronous word select. 0 = left, 1 = right.
- `i2s_din` in 1: asynchronous serial data.
- `l_data` out `DATA_W`: last complete left word.
- `r_data` out `DATA_W`: last complete right word, paired with `l_data`.
- `sample_valid` out 1: one-cycle strobe when a new `l_data`/`r_data` pair is loaded.
- `frame_err` out 1: one-cycle strobe when the completing slot was shorter than `DATA_W` or longer than `SLOT_MAX`.

## Operation
- Synchronise `i2s_bclk`, `i2s_lrck` and `i2s_din` with 2-FF synchronisers each. Register the synced BCLK once more to detect its rising edge (`bclk_rise`).
- All protocol state advances only on `bclk_rise`. On each edge, sample the synced `lr` and `din`.
- Slot boundary: the sampled `lr` differs from `lr_prev`.
  - The bit sampled on that edge is the last bit of the *previous* slot (standard I2S one-bit delay).
  - The next edge carries the MSB of the new slot.
- `bit_cnt` counts bits within a slot:
  - Increments per edge.
  - Saturates at `SLOT_MAX`+1.
  - Resets to 0 on the edge after a boundary.
- Bits at index 0..`DATA_W`-1 shift into `word_sr`, MSB first. Bits beyond `DATA_W` are ignored.
- At a boundary, the slot length is `bit_cnt`+1, including the boundary bit.
  - If the length is < `DATA_W`, left-justify the partial word and zero-fill the remaining LSBs.
  - Either error condition (length < `DATA_W` or > `SLOT_MAX`) strobes `frame_err`.
- State machine:
  - `HUNT`: after reset, wait for the first boundary. Discard the partial slot and do not flag it.
  - `LEFT`: a boundary with `lr_prev`=0 latches the word into `l_hold`, sets `l_ok`, and moves to `RIGHT`.
  - `RIGHT`: a boundary with `lr_prev`=1 does the following, then returns to `LEFT`:
    - If `l_ok` is set, load `l_data`←`l_hold` and `r_data`←word, strobe `sample_valid`, and clear `l_ok`.
    - If `l_ok` is clear, drop the right word with no output.
- A boundary entering `HUNT`→`LEFT` requires the new `lr`=0. If the first boundary enters right, stay in `HUNT` until the next boundary.
- An errored slot still updates the outputs (zero-filled or truncated). `frame_err` and `sample_valid` may assert in the same cycle.
- Reset values:
  - `l_data`=0, `r_data`=0, `sample_valid`=0, `frame_err`=0.
  - State = `HUNT`, `l_ok`=0, `bit_cnt`=0.
  - Synchronisers cleared to 0.
- Reset mid-frame: the whole partial frame is discarded, and the first `sample_valid` comes only after a full left slot followed by a full right slot.

## Timing
- Latency: `sample_valid` rises exactly 4 `clk_p` cycles after the BCLK rising edge at the pins that samples the LRCK 1→0 change (2 sync + 1 edge detect + 1 output register).
- `l_data` and `r_data` change only in the `sample_valid` cycle and hold until the next strobe.
- LRCK and DIN must be stable across the BCLK rising edge ± 1 `clk_p` cycle. This holds automatically at BCLK ≤ `clk_p`/4 when the source changes them on the falling edge.
- Throughput: one stereo sample per LRCK period. There is no back-pressure; the consumer must accept each strobe.

## Structure
- Package `i2s_pkg` holds:
  - the `DATA_W`/`SLOT_MAX` defaults;
  - `LR_LEFT`=1'b0;
  - the state enum (`HUNT`, `LEFT`, `RIGHT`).
- One natural sub-module, `i2s_sync_edge`: 3-bit 2-FF synchroniser plus BCLK rising-edge detector. It outputs synced `lr`, `din` and `bclk_rise`.

## Test plan
- Startup capture: BCLK = `clk_p`/16, 32-bit slots, L=16'h1234, R=16'hABCD repeated.
  - The first frame after reset starts mid-left and is discarded.
  - Then `l_data`=1234 and `r_data`=ABCD with one `sample_valid` per frame.
  - `sample_valid` lands 4 cycles after the LRCK-fall edge.
  - `frame_err` stays 0.
- Loopback: drive from the board's I2S transmitter with a 16-bit audio word of 16'h4000 (speaker=1) toggling to 0 → `r_data` and `l_data` track each value, one frame later.
- Short slots: 12-bit slots carrying 12'hABC → `l_data`=16'hABC0 and `frame_err` strobes with every boundary.
- Long slot: one 70-bit left slot → `frame_err` strobes on its boundary. The next normal frame is captured correctly.
- Reset mid-frame: assert `reset` for 1 cycle halfway through a right slot.
  - Outputs go to 0.
  - There is no `sample_valid` until a complete left+right pair has been received.
- Right-first start: reset while LRCK=0, so the first boundary enters right → no output until the following left/right pair completes.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared defaults and receiver state encoding for the I2S receive path.
package i2s_pkg;

  localparam int   I2S_DATA_W   = 16;
  localparam int   I2S_SLOT_MAX = 64;
  localparam logic LR_LEFT      = 1'b0;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings BCLK/LRCK/DIN into the clk_p domain and produces a one-cycle pulse per
// BCLK rising edge, with lr/din registered so they line up with that pulse.
module i2s_sync_edge (
  input  logic clk_p,
  input  logic reset,
  input  logic i2s_bclk,
  input  logic i2s_lrck,
  input  logic i2s_din,
  output logic lr,
  output logic din,
  output logic bclk_rise
);

  logic [2:0] meta_r;
  logic [2:0] sync_r;
  logic       bclk_d_r;
  logic       lr_r;
  logic       din_r;
  logic       rise_r;

  // Two-flop synchroniser followed by the edge-detect / alignment stage.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      meta_r   <= 3'b000;
      sync_r   <= 3'b000;
      bclk_d_r <= 1'b0;
      lr_r     <= 1'b0;
      din_r    <= 1'b0;
      rise_r   <= 1'b0;
    end else begin
      meta_r   <= {i2s_din, i2s_lrck, i2s_bclk};
      sync_r   <= meta_r;
      bclk_d_r <= sync_r[0];
      rise_r   <= sync_r[0] & ~bclk_d_r;
      lr_r     <= sync_r[1];
      din_r    <= sync_r[2];
    end
  end

  assign lr        = lr_r;
  assign din       = din_r;
  assign bclk_rise = rise_r;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: recovers MSB-first, one-bit-delayed left/right words and presents
// them as a paired stereo sample with a one-cycle valid strobe.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W   = I2S_DATA_W,
  parameter int SLOT_MAX = I2S_SLOT_MAX
) (
  input  logic              clk_p,
  input  logic              reset,
  input  logic              i2s_bclk,
  input  logic              i2s_lrck,
  input  logic              i2s_din,
  output logic [DATA_W-1:0] l_data,
  output logic [DATA_W-1:0] r_data,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int               CNT_W      = $clog2(SLOT_MAX + 3);
  localparam logic [CNT_W-1:0] DATA_W_C   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SLOT_MAX_C = CNT_W'(SLOT_MAX);
  localparam logic [CNT_W-1:0] SAT_C      = CNT_W'(SLOT_MAX + 1);

  logic              lr_s;
  logic              din_s;
  logic              bclk_rise_s;

  i2s_state_e        state_r,   state_nxt_s;
  logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [DATA_W-1:0] word_sr_r, word_sr_nxt_s;
  logic              lr_prev_r, lr_prev_nxt_s;
  logic [DATA_W-1:0] l_hold_r,  l_hold_nxt_s;
  logic              l_ok_r,    l_ok_nxt_s;
  logic [DATA_W-1:0] l_data_nxt_s;
  logic [DATA_W-1:0] r_data_nxt_s;
  logic              valid_nxt_s;
  logic              err_nxt_s;

  logic [CNT_W-1:0]  slot_len_s;
  logic              slot_bad_s;
  logic [DATA_W-1:0] word_full_s;
  logic [DATA_W-1:0] word_just_s;

  i2s_sync_edge u_sync (
    .clk_p     (clk_p),
    .reset     (reset),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_din   (i2s_din),
    .lr        (lr_s),
    .din       (din_s),
    .bclk_rise (bclk_rise_s)
  );

  // The boundary bit still belongs to the closing slot; short slots are left-justified.
  assign slot_len_s  = bit_cnt_r + CNT_W'(1);
  assign slot_bad_s  = (slot_len_s < DATA_W_C) || (slot_len_s > SLOT_MAX_C);
  assign word_full_s = (bit_cnt_r < DATA_W_C) ? {word_sr_r[DATA_W-2:0], din_s} : word_sr_r;
  assign word_just_s = (slot_len_s < DATA_W_C) ? (word_full_s << (DATA_W_C - slot_len_s))
                                               : word_full_s;

  // Next-state and output decode, advanced only on a synchronised BCLK rising edge.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    word_sr_nxt_s = word_sr_r;
    lr_prev_nxt_s = lr_prev_r;
    l_hold_nxt_s  = l_hold_r;
    l_ok_nxt_s    = l_ok_r;
    l_data_nxt_s  = l_data;
    r_data_nxt_s  = r_data;
    valid_nxt_s   = 1'b0;
    err_nxt_s     = 1'b0;
    if (bclk_rise_s) begin
      lr_prev_nxt_s = lr_s;
      if (lr_s != lr_prev_r) begin
        bit_cnt_nxt_s = '0;
        word_sr_nxt_s = '0;
        case (state_r)
          HUNT: begin
            if (lr_s == LR_LEFT) begin
              state_nxt_s = LEFT;
            end else begin
              state_nxt_s = HUNT;
            end
          end
          LEFT: begin
            l_hold_nxt_s = word_just_s;
            l_ok_nxt_s   = 1'b1;
            err_nxt_s    = slot_bad_s;
            state_nxt_s  = RIGHT;
          end
          RIGHT: begin
            err_nxt_s   = slot_bad_s;
            l_ok_nxt_s  = 1'b0;
            state_nxt_s = LEFT;
            if (l_ok_r) begin
              l_data_nxt_s = l_hold_r;
              r_data_nxt_s = word_just_s;
              valid_nxt_s  = 1'b1;
            end else begin
              valid_nxt_s  = 1'b0;
            end
          end
          default: begin
            state_nxt_s = HUNT;
          end
        endcase
      end else begin
        if (bit_cnt_r < DATA_W_C) begin
          word_sr_nxt_s = {word_sr_r[DATA_W-2:0], din_s};
        end else begin
          word_sr_nxt_s = word_sr_r;
        end
        if (bit_cnt_r < SAT_C) begin
          bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
        end else begin
          bit_cnt_nxt_s = bit_cnt_r;
        end
      end
    end else begin
      lr_prev_nxt_s = lr_prev_r;
    end
  end

  // State, slot tracking and registered outputs.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      state_r      <= HUNT;
      bit_cnt_r    <= '0;
      word_sr_r    <= '0;
      lr_prev_r    <= 1'b0;
      l_hold_r     <= '0;
      l_ok_r       <= 1'b0;
      l_data       <= '0;
      r_data       <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      word_sr_r    <= word_sr_nxt_s;
      lr_prev_r    <= lr_prev_nxt_s;
      l_hold_r     <= l_hold_nxt_s;
      l_ok_r       <= l_ok_nxt_s;
      l_data       <= l_data_nxt_s;
      r_data       <= r_data_nxt_s;
      sample_valid <= valid_nxt_s;
      frame_err    <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: builds a serial I2S stream from slot descriptions, predicts
// the stereo samples and error strobes at slot level, and checks them per cycle.
module tb_i2s_rx;

  logic        clk_p = 1'b0;
  logic        reset = 1'b1;
  logic        i2s_bclk = 1'b0;
  logic        i2s_lrck = 1'b0;
  logic        i2s_din = 1'b0;
  logic [15:0] l_data;
  logic [15:0] r_data;
  logic        sample_valid;
  logic        frame_err;

  i2s_rx #(.DATA_W(16), .SLOT_MAX(64)) dut (
    .clk_p        (clk_p),
    .reset        (reset),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_din      (i2s_din),
    .l_data       (l_data),
    .r_data       (r_data),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 clk_p = ~clk_p;

  typedef struct {
    bit          slr;
    bit          din;
    bit          rst;
    int          lo;
    int          hi;
    bit          ev;
    bit          ev_v;
    bit          ev_e;
    logic [15:0] ev_l;
    logic [15:0] ev_r;
  } per_t;

  typedef struct {
    int          t;
    bit          v;
    bit          e;
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  per_t        per_q[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] cur_l = 16'h0000;
  logic [15:0] cur_r = 16'h0000;
  bit          skip = 1'b1;

  // slot-level reference state
  bit           m_sync = 1'b0;
  bit           m_have_l = 1'b0;
  logic [15:0]  m_hold = 16'h0000;
  bit           has_prev = 1'b0;
  bit           p_lr = 1'b0;
  int           p_len = 0;
  logic [127:0] p_val = '0;
  int           half = 8;

  always @(posedge clk_p) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] slot_word(input logic [127:0] v, input int n);
    logic [127:0] t;
    if (n >= 16) t = v >> (n - 16);
    else         t = v << (16 - n);
    return t[15:0];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // The slot that just closed decides the event attached to its last bit period.
  task automatic close_slot();
    per_t        q;
    logic [15:0] w;
    bit          e;
    int          idx;
    w   = slot_word(p_val, p_len);
    e   = (p_len < 16) || (p_len > 64);
    idx = per_q.size() - 1;
    q   = per_q[idx];
    if (!m_sync) begin
      if (p_lr) m_sync = 1'b1;
    end else if (!p_lr) begin
      m_hold   = w;
      m_have_l = 1'b1;
      q.ev = e; q.ev_v = 1'b0; q.ev_e = e;
    end else begin
      q.ev = m_have_l | e; q.ev_v = m_have_l; q.ev_e = e;
      q.ev_l = m_hold; q.ev_r = w;
      m_have_l = 1'b0;
    end
    per_q[idx] = q;
  endtask

  task automatic add_slot(input bit lr, input int len, input logic [127:0] val, input int rst_at);
    per_t p;
    if (has_prev && (lr != p_lr)) close_slot();
    for (int i = 0; i < len; i++) begin
      p = '{default: 0};
      p.slr = lr;
      p.din = val[len-1-i];
      p.rst = (i == rst_at);
      p.lo  = (half > 0) ? half : int'($urandom_range(3, 8));
      p.hi  = (half > 0) ? half : int'($urandom_range(3, 8));
      per_q.push_back(p);
    end
    if (rst_at >= 0) begin
      m_sync   = 1'b0;
      m_have_l = 1'b0;
    end
    has_prev = 1'b1; p_lr = lr; p_len = len; p_val = val;
  endtask

  task automatic pulse_reset();
    @(negedge clk_p); reset = 1'b1; skip = 1'b1;
    @(negedge clk_p); reset = 1'b0; cur_l = 16'h0000; cur_r = 16'h0000;
    check_eq("rst_l_data", l_data, 32'h0);
    check_eq("rst_r_data", r_data, 32'h0);
    check_eq("rst_strobes", {sample_valid, frame_err}, 32'h0);
    @(negedge clk_p); skip = 1'b0;
  endtask

  task automatic play();
    per_t p;
    exp_t e;
    for (int i = 0; i < per_q.size(); i++) begin
      p = per_q[i];
      @(negedge clk_p);
      i2s_bclk = 1'b0;
      i2s_lrck = (i + 1 < per_q.size()) ? per_q[i+1].slr : p.slr;
      i2s_din  = p.din;
      if (p.rst) pulse_reset();
      repeat (p.lo - 1) @(negedge clk_p);
      i2s_bclk = 1'b1;
      if (p.ev) begin
        e.t = cyc + 4; e.v = p.ev_v; e.e = p.ev_e; e.l = p.ev_l; e.r = p.ev_r;
        exp_q.push_back(e);
      end
      repeat (p.hi - 1) @(negedge clk_p);
    end
  endtask

  // Per-cycle monitor: strobes must match predicted events exactly; data must hold otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_p);
      if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
        e = exp_q.pop_front();
        check_eq("sample_valid", sample_valid, e.v);
        check_eq("frame_err", frame_err, e.e);
        if (e.v) begin
          check_eq("l_data", l_data, e.l);
          check_eq("r_data", r_data, e.r);
          cur_l = e.l;
          cur_r = e.r;
        end
      end else begin
        if (sample_valid || frame_err)
          check_eq("spurious_strobe", {sample_valid, frame_err}, 32'h0);
        if (exp_q.size() > 0 && exp_q[0].t < cyc) begin
          check_eq("missed_event", exp_q[0].t, cyc);
          void'(exp_q.pop_front());
        end
        if (!skip) begin
          check_eq("l_hold", l_data, cur_l);
          check_eq("r_hold", r_data, cur_r);
        end
      end
    end
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    // startup capture at BCLK = clk_p/16, first frame begins mid-left
    half = 8;
    add_slot(1'b0, 20, rnd128(), -1);
    for (int f = 0; f < 3; f++) begin
      add_slot(1'b1, 32, {96'h0, 16'hABCD, 16'($urandom)}, -1);
      add_slot(1'b0, 32, {96'h0, 16'h1234, 16'($urandom)}, -1);
    end
    add_slot(1'b1, 32, {96'h0, 16'hABCD, 16'($urandom)}, -1);
    // random data, random BCLK phases from here on
    half = 0;
    for (int f = 0; f < 5; f++) begin
      add_slot(1'b0, 32, rnd128(), -1);
      add_slot(1'b1, 32, rnd128(), -1);
    end
    // loopback pattern: 16-bit words toggling 4000 / 0
    for (int f = 0; f < 4; f++) begin
      a = (f % 2 == 0) ? 16'h4000 : 16'h0000;
      add_slot(1'b0, 16, {112'h0, a}, -1);
      add_slot(1'b1, 16, {112'h0, a}, -1);
    end
    // short 12-bit slots
    for (int f = 0; f < 4; f++) begin
      add_slot(1'b0, 12, {116'h0, 12'hABC}, -1);
      add_slot(1'b1, 12, {116'h0, 12'hABC}, -1);
    end
    // one over-long left slot, then normal frames
    add_slot(1'b0, 70, rnd128(), -1);
    add_slot(1'b1, 32, rnd128(), -1);
    add_slot(1'b0, 32, rnd128(), -1);
    add_slot(1'b1, 32, rnd128(), -1);
    // reset halfway through a right slot
    add_slot(1'b0, 32, rnd128(), -1);
    add_slot(1'b1, 32, rnd128(), 16);
    for (int f = 0; f < 2; f++) begin
      add_slot(1'b0, 32, rnd128(), -1);
      add_slot(1'b1, 32, rnd128(), -1);
    end
    // reset while LRCK=0: first boundary enters right
    add_slot(1'b0, 32, rnd128(), 10);
    add_slot(1'b1, 32, rnd128(), -1);
    for (int f = 0; f < 2; f++) begin
      b = 16'($urandom);
      add_slot(1'b0, 32, {96'h0, b, 16'($urandom)}, -1);
      add_slot(1'b1, 32, rnd128(), -1);
    end
    add_slot(1'b0, 8, rnd128(), -1);

    repeat (3) @(negedge clk_p);
    check_eq("reset_l_data", l_data, 32'h0);
    check_eq("reset_r_data", r_data, 32'h0);
    check_eq("reset_strobes", {sample_valid, frame_err}, 32'h0);
    reset = 1'b0;
    @(negedge clk_p);
    skip = 1'b0;
    play();
    repeat (20) @(negedge clk_p);
    check_eq("pending_events", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
